// File: rtl/csr_arb_pkg.sv
// Shared types for the CSR access arbiter: FSM states, CSR op encodings,
// requester identity and the latched command payload.
package csr_arb_pkg;

    localparam int unsigned CSR_ADDR_W = 12;
    localparam int unsigned CSR_OP_W   = 2;

    typedef logic [CSR_OP_W-1:0] csr_op_t;

    localparam csr_op_t CSR_OP_READ  = 2'b00;
    localparam csr_op_t CSR_OP_WRITE = 2'b01;
    localparam csr_op_t CSR_OP_SET   = 2'b10;
    localparam csr_op_t CSR_OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } arb_state_e;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } req_id_e;

    typedef struct packed {
        req_id_e                 id;
        logic [CSR_ADDR_W-1:0]   addr;
        csr_op_t                 op;
    } csr_cmd_t;

    // Every op except a plain read needs a write-back cycle.
    function automatic logic op_modifies(input csr_op_t op);
        return op != CSR_OP_READ;
    endfunction

endpackage

// File: rtl/csr_arb_starve_ctr.sv
// Saturating count of arbitrations the debug requester has lost to the core;
// clear has priority over increment.
module csr_arb_starve_ctr #(
    parameter int unsigned LIMIT = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_W'(LIMIT))) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/csr_access_arbiter.sv
// Arbitrates core and debug requesters onto a single CSR file port, running one
// read / read-modify-write access at a time with anti-starvation for debug.
module csr_access_arbiter
    import csr_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  core_req,
    input  logic [11:0]           core_addr,
    input  logic [1:0]            core_op,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_gnt,
    output logic                  core_rvalid,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_err,

    input  logic                  dbg_req,
    input  logic [11:0]           dbg_addr,
    input  logic [1:0]            dbg_op,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  dbg_err,

    input  logic                  trap_busy,

    output logic [11:0]           csr_addr,
    output logic [1:0]            csr_op,
    output logic [DATA_WIDTH-1:0] csr_write_data,
    input  logic [DATA_WIDTH-1:0] csr_read_data,
    input  logic                  csr_error
);

    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    arb_state_e            state_q, state_d;
    csr_cmd_t              cmd_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] core_rdata_q, dbg_rdata_q;
    logic                  core_err_q, dbg_err_q;
    logic                  core_rvalid_q, dbg_rvalid_q;
    logic                  grant_core_c, grant_dbg_c;
    logic [CNT_W-1:0]      starve_cnt;
    logic                  starved_c;

    assign starved_c = (starve_cnt == CNT_W'(STARVE_LIMIT));

    csr_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (CNT_W)
    ) u_starve_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (grant_core_c & dbg_req),
        .clr   (grant_dbg_c),
        .count (starve_cnt)
    );

    // Next state and same-cycle grant; grants are held off while reset is asserted.
    always_comb begin
        state_d      = state_q;
        grant_core_c = 1'b0;
        grant_dbg_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_n && !trap_busy) begin
                    if (dbg_req && (!core_req || starved_c)) begin
                        grant_dbg_c = 1'b1;
                    end else if (core_req) begin
                        grant_core_c = 1'b1;
                    end
                    if (core_req || dbg_req) begin
                        state_d = RD;
                    end
                end
            end
            RD:      state_d = (op_modifies(cmd_q.op) && !csr_error) ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, latched command, captured read result and response strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cmd_q         <= '0;
            wdata_q       <= '0;
            core_rdata_q  <= '0;
            dbg_rdata_q   <= '0;
            core_err_q    <= 1'b0;
            dbg_err_q     <= 1'b0;
            core_rvalid_q <= 1'b0;
            dbg_rvalid_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_dbg_c) begin
                cmd_q   <= '{id: REQ_DBG, addr: dbg_addr, op: dbg_op};
                wdata_q <= dbg_wdata;
            end else if (grant_core_c) begin
                cmd_q   <= '{id: REQ_CORE, addr: core_addr, op: core_op};
                wdata_q <= core_wdata;
            end
            if (state_q == RD) begin
                if (cmd_q.id == REQ_DBG) begin
                    dbg_rdata_q <= csr_read_data;
                    dbg_err_q   <= csr_error;
                end else begin
                    core_rdata_q <= csr_read_data;
                    core_err_q   <= csr_error;
                end
            end
            core_rvalid_q <= (state_d == RESP) && (cmd_q.id == REQ_CORE);
            dbg_rvalid_q  <= (state_d == RESP) && (cmd_q.id == REQ_DBG);
        end
    end

    assign core_gnt    = grant_core_c;
    assign dbg_gnt     = grant_dbg_c;
    assign core_rvalid = core_rvalid_q;
    assign dbg_rvalid  = dbg_rvalid_q;
    assign core_rdata  = core_rdata_q;
    assign dbg_rdata   = dbg_rdata_q;
    assign core_err    = core_err_q;
    assign dbg_err     = dbg_err_q;

    // CSR file port: address only while an access is in flight, op/data only in WR.
    assign csr_addr       = (state_q == IDLE) ? '0 : cmd_q.addr;
    assign csr_op         = (state_q == WR) ? cmd_q.op : CSR_OP_READ;
    assign csr_write_data = (state_q == WR) ? wdata_q : '0;

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Directed bench for csr_access_arbiter with a one-register CSR file model
// (mscratch at 0x340, every other address illegal).
module tb_csr_access_arbiter;
    import csr_arb_pkg::*;

    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          core_req, dbg_req, trap_busy;
    logic [11:0]   core_addr, dbg_addr;
    logic [1:0]    core_op, dbg_op;
    logic [DW-1:0] core_wdata, dbg_wdata;
    logic          core_gnt, core_rvalid, core_err;
    logic          dbg_gnt, dbg_rvalid, dbg_err;
    logic [DW-1:0] core_rdata, dbg_rdata;
    logic [11:0]   csr_addr;
    logic [1:0]    csr_op;
    logic [DW-1:0] csr_write_data, csr_read_data;
    logic          csr_error;
    logic [DW-1:0] mscratch = 64'h1234;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    csr_access_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .core_req       (core_req),
        .core_addr      (core_addr),
        .core_op        (core_op),
        .core_wdata     (core_wdata),
        .core_gnt       (core_gnt),
        .core_rvalid    (core_rvalid),
        .core_rdata     (core_rdata),
        .core_err       (core_err),
        .dbg_req        (dbg_req),
        .dbg_addr       (dbg_addr),
        .dbg_op         (dbg_op),
        .dbg_wdata      (dbg_wdata),
        .dbg_gnt        (dbg_gnt),
        .dbg_rvalid     (dbg_rvalid),
        .dbg_rdata      (dbg_rdata),
        .dbg_err        (dbg_err),
        .trap_busy      (trap_busy),
        .csr_addr       (csr_addr),
        .csr_op         (csr_op),
        .csr_write_data (csr_write_data),
        .csr_read_data  (csr_read_data),
        .csr_error      (csr_error)
    );

    // CSR file model: combinational read, write/set/clear applied at the edge.
    always_comb begin
        csr_read_data = 64'hDEAD;
        csr_error     = 1'b1;
        if (csr_addr == 12'h340) begin
            csr_read_data = mscratch;
            csr_error     = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (csr_addr == 12'h340) begin
            case (csr_op)
                CSR_OP_WRITE: mscratch <= csr_write_data;
                CSR_OP_SET:   mscratch <= mscratch | csr_write_data;
                CSR_OP_CLEAR: mscratch <= mscratch & ~csr_write_data;
                default:      ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_core_gnt"},   64'(core_gnt), 64'd0);
        check({tag, "_dbg_gnt"},    64'(dbg_gnt), 64'd0);
        check({tag, "_core_rv"},    64'(core_rvalid), 64'd0);
        check({tag, "_dbg_rv"},     64'(dbg_rvalid), 64'd0);
        check({tag, "_core_rdata"}, core_rdata, 64'd0);
        check({tag, "_dbg_rdata"},  dbg_rdata, 64'd0);
        check({tag, "_core_err"},   64'(core_err), 64'd0);
        check({tag, "_dbg_err"},    64'(dbg_err), 64'd0);
        check({tag, "_csr_op"},     64'(csr_op), 64'd0);
        check({tag, "_csr_addr"},   64'(csr_addr), 64'd0);
        check({tag, "_csr_wdata"},  csr_write_data, 64'd0);
    endtask

    // One full access from a single requester: grant, latency, WR cycles, response.
    task automatic do_access(input string tag, input bit is_dbg, input logic [11:0] a,
                             input logic [1:0] o, input logic [63:0] w,
                             input logic [63:0] exp_rdata, input bit exp_err, input bit trap_mid);
        int  lat;
        int  wr_cycles;
        bit  got;
        int  exp_lat;
        exp_lat = (o != CSR_OP_READ && !exp_err) ? 3 : 2;
        if (is_dbg) begin
            dbg_req = 1'b1; dbg_addr = a; dbg_op = o; dbg_wdata = w;
        end else begin
            core_req = 1'b1; core_addr = a; core_op = o; core_wdata = w;
        end
        #1;
        check({tag, "_gnt"},   64'(is_dbg ? dbg_gnt : core_gnt), 64'd1);
        check({tag, "_nogntx"}, 64'(is_dbg ? core_gnt : dbg_gnt), 64'd0);
        step();
        // Scramble request fields after grant; the latched access must be unaffected.
        core_req = 1'b0; dbg_req = 1'b0; trap_busy = trap_mid;
        core_addr = 12'hFFF; core_op = 2'b11; core_wdata = '1;
        dbg_addr = 12'hFFF;  dbg_op = 2'b11;  dbg_wdata = '1;
        lat = 0; wr_cycles = 0; got = 1'b0;
        for (int c = 1; c <= 6 && !got; c++) begin
            #1;
            if (csr_op != CSR_OP_READ) begin
                wr_cycles++;
                check({tag, "_wr_op"},   64'(csr_op), 64'(o));
                check({tag, "_wr_addr"}, 64'(csr_addr), 64'(a));
                check({tag, "_wr_data"}, csr_write_data, w);
            end
            if (is_dbg ? dbg_rvalid : core_rvalid) begin
                got = 1'b1;
                lat = c;
                check({tag, "_rdata"}, is_dbg ? dbg_rdata : core_rdata, exp_rdata);
                check({tag, "_err"},   64'(is_dbg ? dbg_err : core_err), 64'(exp_err));
                check({tag, "_rvx"},   64'(is_dbg ? core_rvalid : dbg_rvalid), 64'd0);
            end
            step();
        end
        check({tag, "_responded"}, 64'(got), 64'd1);
        check({tag, "_latency"},   64'(lat), 64'(exp_lat));
        check({tag, "_wr_cycles"}, 64'(wr_cycles), 64'(exp_lat == 3 ? 1 : 0));
        trap_busy = 1'b0;
        #1;
        check({tag, "_rv_drop"}, 64'(is_dbg ? dbg_rvalid : core_rvalid), 64'd0);
        check({tag, "_hold"},    is_dbg ? dbg_rdata : core_rdata, exp_rdata);
        check({tag, "_idle_addr"}, 64'(csr_addr), 64'd0);
    endtask

    initial begin
        int n;
        int last;
        rst_n = 1'b0; trap_busy = 1'b0;
        core_req = 1'b1; core_addr = 12'h340; core_op = 2'b00; core_wdata = '0;
        dbg_req  = 1'b1; dbg_addr  = 12'h340; dbg_op  = 2'b00; dbg_wdata  = '0;
        #3;
        check_quiet("reset");
        core_req = 1'b0; dbg_req = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        step();

        do_access("core_rd",   1'b0, 12'h340, CSR_OP_READ,  64'h0,    64'h1234, 1'b0, 1'b0);
        do_access("dbg_wr",    1'b1, 12'h340, CSR_OP_WRITE, 64'hABCD, 64'h1234, 1'b0, 1'b0);
        do_access("rd_back",   1'b0, 12'h340, CSR_OP_READ,  64'h0,    64'hABCD, 1'b0, 1'b0);
        do_access("bad_addr",  1'b0, 12'h7C0, CSR_OP_WRITE, 64'h55,   64'hDEAD, 1'b1, 1'b0);
        do_access("core_set",  1'b0, 12'h340, CSR_OP_SET,   64'h00F0, 64'hABCD, 1'b0, 1'b0);
        do_access("dbg_clr",   1'b1, 12'h340, CSR_OP_CLEAR, 64'h000D, 64'hABFD, 1'b0, 1'b0);
        do_access("rd_clr",    1'b1, 12'h340, CSR_OP_READ,  64'h0,    64'hABF0, 1'b0, 1'b0);

        // Both requesters held: four core grants then one debug grant, back to back.
        core_req = 1'b1; core_addr = 12'h340; core_op = CSR_OP_READ;
        dbg_req  = 1'b1; dbg_addr  = 12'h340; dbg_op  = CSR_OP_READ;
        n = 0; last = 0;
        for (int c = 0; c < 100 && n < 10; c++) begin
            #1;
            if (core_gnt || dbg_gnt) begin
                check("starve_who",  64'(dbg_gnt), 64'((n % 5) == 4));
                check("starve_excl", 64'(core_gnt & dbg_gnt), 64'd0);
                if (n > 0) check("starve_gap", 64'(c - last), 64'd3);
                last = c;
                n++;
            end
            step();
        end
        check("starve_grants", 64'(n), 64'd10);
        core_req = 1'b0; dbg_req = 1'b0;
        repeat (4) step();

        // Trap blocks new grants; the grant appears the cycle trap_busy falls.
        trap_busy = 1'b1; core_req = 1'b1; core_addr = 12'h340; core_op = CSR_OP_READ;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("trap_gnt", 64'(core_gnt), 64'd0);
            step();
        end
        trap_busy = 1'b0;
        do_access("trap_rel", 1'b0, 12'h340, CSR_OP_READ, 64'h0, 64'hABF0, 1'b0, 1'b1);

        // Reset during the WR cycle of a set: outputs clear at once, nothing completes.
        core_req = 1'b1; core_addr = 12'h340; core_op = CSR_OP_SET; core_wdata = 64'hF00;
        #1;
        check("rst_mid_gnt", 64'(core_gnt), 64'd1);
        step();
        step();
        #1;
        check("rst_mid_wr", 64'(csr_op), 64'(CSR_OP_SET));
        rst_n = 1'b0;
        #1;
        check_quiet("rst_mid");
        core_req = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("post_rst_rv", 64'(core_rvalid), 64'd0);
            check("post_rst_op", 64'(csr_op), 64'd0);
            step();
        end
        do_access("post_rst_rd", 1'b0, 12'h340, CSR_OP_READ, 64'h0, 64'hABF0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
